// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch stage. Owns the fetch program counter (pc_q), drives it
// to the word-addressed instruction memory and registers the returned word
// together with its address at the IF/ID boundary.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-high reset
//   A                fetch address to instruction memory (always pc_q)
//   RD               instruction word returned combinationally for A
//   stall            hold fetch and IF/ID registers this cycle
//   redirect_valid   load redirect_target into pc_q (flushes instr_valid)
//   redirect_target  new fetch address
//   instr            registered fetched instruction
//   pc               registered address of instr
//   pc_plus4         registered pc + 4
//   instr_valid      instr/pc hold a real fetch
//   fetch_fault      sticky: an illegal fetch address halted the unit
//
// Configuration
//   IFU_BOUNDS_CHECK_EN  when defined, addresses >= IMEM_WORDS*4 are also
//                        treated as illegal and halt the unit. Otherwise only
//                        misaligned addresses fault.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] A,
    input  logic [31:0] RD,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

`ifdef IFU_BOUNDS_CHECK_EN
    localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS) * 32'd4;
`endif

    state_t      state_q,       state_d;
    logic [31:0] pc_q,          pc_d;
    logic [31:0] instr_q,       instr_d;
    logic [31:0] id_pc_q,       id_pc_d;
    logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
    logic        instr_valid_q, instr_valid_d;
    logic        fetch_fault_q, fetch_fault_d;
    logic        illegal_s;
    logic [31:0] pc_next_s;

    // Fetch address legality: misalignment always, range only when enabled.
    function automatic logic is_illegal(input logic [31:0] addr);
`ifdef IFU_BOUNDS_CHECK_EN
        return (addr[1:0] != 2'b00) || (addr >= IMEM_BYTES);
`else
        return (addr[1:0] != 2'b00);
`endif
    endfunction

    assign illegal_s = is_illegal(pc_q);
    // Wraps modulo 2^32 by construction.
    assign pc_next_s = pc_q + 32'd4;

    // Next-state and next-register values for the fetch FSM.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        instr_valid_d = instr_valid_q;
        fetch_fault_d = fetch_fault_q;

        case (state_q)
            IDLE: begin
                // No capture yet; a redirect still lands so the first fetch
                // comes from the target.
                if (redirect_valid) begin
                    pc_d = redirect_target;
                end else begin
                    pc_d = pc_q;
                end
                instr_valid_d = 1'b0;
                state_d       = RUN;
            end
            RUN: begin
                if (redirect_valid) begin
                    // Flush: the word on RD belongs to the old stream.
                    pc_d          = redirect_target;
                    instr_valid_d = 1'b0;
                end else if (stall) begin
                    state_d = RUN;
                end else if (illegal_s) begin
                    instr_valid_d = 1'b0;
                    fetch_fault_d = 1'b1;
                    state_d       = HALT;
                end else begin
                    instr_d       = RD;
                    id_pc_d       = pc_q;
                    id_pc_plus4_d = pc_next_s;
                    instr_valid_d = 1'b1;
                    pc_d          = pc_next_s;
                end
            end
            HALT: begin
                // Frozen until reset; inputs are ignored.
                instr_valid_d = 1'b0;
                fetch_fault_d = 1'b1;
                state_d       = HALT;
            end
            default: begin
                // Unreachable encoding: stop fetching and flag it.
                instr_valid_d = 1'b0;
                fetch_fault_d = 1'b1;
                state_d       = HALT;
            end
        endcase
    end

    // State and IF/ID register bank with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= NOP_INSTR;
            id_pc_q       <= 32'h0000_0000;
            id_pc_plus4_q <= 32'h0000_0000;
            instr_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            instr_valid_q <= instr_valid_d;
            fetch_fault_q <= fetch_fault_d;
        end
    end

    assign A           = pc_q;
    assign instr       = instr_q;
    assign pc          = id_pc_q;
    assign pc_plus4    = id_pc_plus4_q;
    assign instr_valid = instr_valid_q;
    assign fetch_fault = fetch_fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Self-checking bench: directed walk through the fetch scenarios followed by
// randomized stall / redirect / reset traffic, compared every cycle against a
// behavioural model of the fetch unit kept in this file.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam int          IMEM_WORDS = 32;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic [31:0] a_s;
    logic [31:0] rd_s;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] instr_s;
    logic [31:0] pc_s;
    logic [31:0] pc_plus4_s;
    logic        instr_valid_s;
    logic        fetch_fault_s;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [IMEM_WORDS];

    // Reference model state.
    int          m_phase;   // 0 = waiting one edge after reset, 1 = fetching, 2 = halted
    logic [31:0] m_fpc;
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic        m_fault;

    instr_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .IMEM_WORDS (IMEM_WORDS)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .A               (a_s),
        .RD              (rd_s),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .instr           (instr_s),
        .pc              (pc_s),
        .pc_plus4        (pc_plus4_s),
        .instr_valid     (instr_valid_s),
        .fetch_fault     (fetch_fault_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents for any address; beyond the array a fixed pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr < 32'(IMEM_WORDS * 4)) return mem[addr[6:2]];
        return addr ^ 32'h5A5A_A5A5;
    endfunction

    // Combinational instruction memory.
    always_comb begin
        rd_s = mem_word(a_s);
    end

    function automatic bit addr_bad(input logic [31:0] addr);
        bit bad;
        bad = (addr % 32'd4) != 32'd0;
`ifdef IFU_BOUNDS_CHECK_EN
        if (addr >= 32'(IMEM_WORDS * 4)) bad = 1'b1;
`endif
        return bad;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_fpc   = RESET_PC;
        m_instr = NOP_INSTR;
        m_pc    = 32'd0;
        m_pc4   = 32'd0;
        m_valid = 1'b0;
        m_fault = 1'b0;
    endtask

    // One clock edge of the reference behaviour.
    task automatic model_edge(input bit st, input bit rv, input logic [31:0] tgt);
        if (m_phase == 0) begin
            if (rv) m_fpc = tgt;
            m_valid = 1'b0;
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (rv) begin
                m_fpc   = tgt;
                m_valid = 1'b0;
            end else if (!st) begin
                if (addr_bad(m_fpc)) begin
                    m_valid = 1'b0;
                    m_fault = 1'b1;
                    m_phase = 2;
                end else begin
                    m_instr = mem_word(m_fpc);
                    m_pc    = m_fpc;
                    m_pc4   = m_fpc + 32'd4;
                    m_valid = 1'b1;
                    m_fpc   = m_fpc + 32'd4;
                end
            end
        end
    endtask

    task automatic check_all();
        check_eq("A",           a_s,                    m_fpc);
        check_eq("instr",       instr_s,                m_instr);
        check_eq("pc",          pc_s,                   m_pc);
        check_eq("pc_plus4",    pc_plus4_s,             m_pc4);
        check_eq("instr_valid", {31'd0, instr_valid_s}, {31'd0, m_valid});
        check_eq("fetch_fault", {31'd0, fetch_fault_s}, {31'd0, m_fault});
    endtask

    // Called at a falling edge: drive inputs, take one rising edge, check.
    task automatic cycle(input bit st, input bit rv, input logic [31:0] tgt);
        stall           = st;
        redirect_valid  = rv;
        redirect_target = tgt;
        @(posedge clk);
        model_edge(st, rv, tgt);
        @(negedge clk);
        check_all();
    endtask

    // Called at a falling edge: pulse reset between clock edges.
    task automatic do_reset();
        stall          = 1'b0;
        redirect_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < IMEM_WORDS; i++) mem[i] = $urandom;
        mem[0]  = 32'h0010_0093;
        mem[1]  = 32'h0020_0113;
        mem[2]  = 32'h0020_81B3;
        mem[3]  = 32'h4021_8233;
        mem[13] = 32'h0040_06EF;
        mem[14] = 32'h0261_8063;

        reset           = 1'b1;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;
        model_reset();
        @(negedge clk);
        check_all();
        check_eq("rst_instr", instr_s, NOP_INSTR);
        reset = 1'b0;

        // Start-up and sequential fetch.
        cycle(1'b0, 1'b0, 32'd0);
        check_eq("e1_valid", {31'd0, instr_valid_s}, 32'd0);
        cycle(1'b0, 1'b0, 32'd0);
        check_eq("e2_instr", instr_s, 32'h0010_0093);
        check_eq("e2_pc", pc_s, 32'd0);
        check_eq("e2_pc4", pc_plus4_s, 32'd4);
        cycle(1'b0, 1'b0, 32'd0);
        check_eq("e3_instr", instr_s, 32'h0020_0113);
        check_eq("e3_pc", pc_s, 32'd4);
        cycle(1'b0, 1'b0, 32'd0);
        check_eq("e4_A", a_s, 32'h0000_000C);

        // Stall for three cycles.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 32'd0);
            check_eq("stall_instr", instr_s, 32'h0020_81B3);
            check_eq("stall_pc", pc_s, 32'd8);
            check_eq("stall_A", a_s, 32'h0000_000C);
        end
        cycle(1'b0, 1'b0, 32'd0);
        check_eq("unstall_instr", instr_s, 32'h4021_8233);
        check_eq("unstall_pc", pc_s, 32'h0000_000C);
        check_eq("pre_redir_A", a_s, 32'h0000_0010);

        // Redirect bubble.
        cycle(1'b0, 1'b1, 32'h0000_0034);
        check_eq("redir_valid", {31'd0, instr_valid_s}, 32'd0);
        check_eq("redir_A", a_s, 32'h0000_0034);
        cycle(1'b0, 1'b0, 32'd0);
        check_eq("redir_instr", instr_s, 32'h0040_06EF);
        check_eq("redir_pc", pc_s, 32'h0000_0034);

        // Redirect beats stall.
        cycle(1'b1, 1'b1, 32'h0000_0038);
        check_eq("rs_A", a_s, 32'h0000_0038);
        check_eq("rs_valid", {31'd0, instr_valid_s}, 32'd0);
        cycle(1'b0, 1'b0, 32'd0);
        check_eq("rs_instr", instr_s, 32'h0261_8063);

        // Misaligned redirect, fault, halt, reset recovery.
        cycle(1'b0, 1'b1, 32'h0000_0022);
        check_eq("mis_A", a_s, 32'h0000_0022);
        check_eq("mis_nofault", {31'd0, fetch_fault_s}, 32'd0);
        cycle(1'b0, 1'b0, 32'd0);
        check_eq("mis_fault", {31'd0, fetch_fault_s}, 32'd1);
        check_eq("mis_valid", {31'd0, instr_valid_s}, 32'd0);
        cycle(1'b0, 1'b1, 32'h0000_0040);
        check_eq("halt_A", a_s, 32'h0000_0022);
        check_eq("halt_fault", {31'd0, fetch_fault_s}, 32'd1);
        do_reset();
        check_eq("areset_fault", {31'd0, fetch_fault_s}, 32'd0);
        check_eq("areset_A", a_s, RESET_PC);

        // Run off the end of memory.
        cycle(1'b0, 1'b1, 32'h0000_0070);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'd0);
        check_eq("end_A", a_s, 32'h0000_0080);
        cycle(1'b0, 1'b0, 32'd0);
`ifdef IFU_BOUNDS_CHECK_EN
        check_eq("oob_fault", {31'd0, fetch_fault_s}, 32'd1);
        check_eq("oob_valid", {31'd0, instr_valid_s}, 32'd0);
`else
        check_eq("oob_fault", {31'd0, fetch_fault_s}, 32'd0);
        check_eq("oob_valid", {31'd0, instr_valid_s}, 32'd1);
        check_eq("oob_pc", pc_s, 32'h0000_0080);
        check_eq("oob_instr", instr_s, 32'h0000_0080 ^ 32'h5A5A_A5A5);
`endif
        do_reset();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            bit          st;
            bit          rv;
            logic [31:0] tgt;
            int          k;
            if (($urandom_range(0, 99) == 0) || (m_phase == 2 && $urandom_range(0, 7) == 0)) begin
                do_reset();
            end else begin
                st = ($urandom_range(0, 99) < 30);
                rv = ($urandom_range(0, 99) < 12);
                k  = $urandom_range(0, 9);
                if (k < 7)       tgt = 32'($urandom_range(0, IMEM_WORDS - 1)) * 32'd4;
                else if (k == 7) tgt = $urandom;
                else if (k == 8) tgt = 32'hFFFF_FFFC;
                else             tgt = 32'($urandom_range(0, IMEM_WORDS * 4 - 1)) | 32'd1;
                cycle(st, rv, tgt);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
